// File: rtl/avmm_mem_test_master_if.sv
// avmm_mem_test_master_if: Avalon-MM bus between the memory test master and a RAM slave.
//   master modport: drives address/byteenable/write/writedata/read,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image, for the RAM side (or a bench model).
interface avmm_mem_test_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                read;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, write, writedata, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, write, writedata, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_mem_test_master.sv
// avmm_mem_test_master: Avalon-MM master that fills a RAM word range with an
// incrementing pattern (seed + i) or reads it back, counting mismatches and summing data.
//   clk, reset_n (async, active low)
//   cmd_start/cmd_op/cmd_addr/cmd_len/cmd_seed : command (op 0 = fill, 1 = verify)
//   busy, done                                 : command status, done is a 1-cycle pulse
//   err_cnt, first_err_addr, sum               : verify results, held until the next start
//   avm                                        : Avalon-MM master port
module avmm_mem_test_master #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_start,
    input  logic                   cmd_op,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [ADDR_W:0]        cmd_len,
    input  logic [DATA_W-1:0]      cmd_seed,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        err_cnt,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [DATA_W-1:0]      sum,
    avmm_mem_test_master_if.master avm
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [3:0] PEND_LIMIT = 4'(MAX_PEND);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W:0]   left;
    logic [3:0]        pend;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_val;

    // Requests come straight from registered state, so they hold still under
    // waitrequest: addr/data/left only move on acceptance, and pend can only
    // fall while a read is stalled.
    assign avm.write      = state == S_WR;
    assign avm.read       = state == S_RD && pend < PEND_LIMIT;
    assign avm.address    = addr;
    assign avm.writedata  = data;
    assign avm.byteenable = {(DATA_W/8){avm.read | avm.write}};
    assign busy           = state != S_IDLE;
    assign done           = state == S_FIN;
    assign wr_acc         = avm.write & ~avm.waitrequest;
    assign rd_acc         = avm.read & ~avm.waitrequest;
    // Data only counts while reading with something outstanding; a zero-latency
    // slave may return it in the very cycle the read is accepted.
    assign rd_val = avm.readdatavalid & (state == S_RD || state == S_DRAIN) & (pend != '0 || rd_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            addr           <= '0;
            exp_addr       <= '0;
            data           <= '0;
            exp_data       <= '0;
            left           <= '0;
            pend           <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            sum            <= '0;
        end else begin
            pend <= pend + 4'(rd_acc) - 4'(rd_val);
            if (wr_acc || rd_acc) begin
                addr <= addr + 1'b1;
                data <= data + 1'b1;
                left <= left - 1'b1;
            end
            if (rd_val) begin
                sum      <= sum + avm.readdata;
                exp_addr <= exp_addr + 1'b1;
                exp_data <= exp_data + 1'b1;
                // err_cnt is one bit wider than the address, so it holds the
                // largest possible word count and never wraps.
                if (avm.readdata != exp_data) begin
                    err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == '0) first_err_addr <= exp_addr;
                end
            end
            case (state)
                S_IDLE: if (cmd_start) begin
                    state          <= cmd_len == '0 ? S_FIN : cmd_op ? S_RD : S_WR;
                    addr           <= cmd_addr;
                    exp_addr       <= cmd_addr;
                    data           <= cmd_seed;
                    exp_data       <= cmd_seed;
                    left           <= cmd_len;
                    err_cnt        <= '0;
                    first_err_addr <= '0;
                    sum            <= '0;
                end
                S_WR:    if (wr_acc && left == LEN_ONE) state <= S_FIN;
                S_RD:    if (rd_acc && left == LEN_ONE) state <= S_DRAIN;
                S_DRAIN: if (pend == '0) state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
